vector_lsu: RTL and testbench

Parametrised vector load/store unit for the interpolation ASIP memory subsystem. It owns a private single-port element RAM and services one vector request at a time, moving LANES elements per request with either unit stride or a signed programmable stride. It replaces the fixed-width vector data path (64-bit in, 128-bit out) with a generic lane count and element width, and adds strided access, range checking and a valid/ready handshake on both the request and response sides.

---
 rtl/vlsu_pkg.sv | 23 ++
 rtl/lsu_ram.sv | 22 ++
 rtl/vector_lsu.sv | 119 +++++++++++
 tb/tb_vector_lsu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_pkg.sv
// Shared types for the vector load/store unit: request opcodes, FSM states and
// an opcode decode helper.
package vlsu_pkg;

    typedef enum logic [1:0] {
        VLSU_LOAD    = 2'd0,
        VLSU_STORE   = 2'd1,
        VLSU_LOAD_S  = 2'd2,
        VLSU_STORE_S = 2'd3
    } vlsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } vlsu_state_e;

    function automatic logic is_store(input vlsu_op_e op);
        return (op == VLSU_STORE) || (op == VLSU_STORE_S);
    endfunction

endpackage

// File: rtl/lsu_ram.sv
// Single-port synchronous element RAM, one-cycle read latency, no reset.
module lsu_ram #(
    parameter int DEPTH  = 1024,
    parameter int ELEM_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [ELEM_W-1:0] wdata,
    output logic [ELEM_W-1:0] rdata
);

    logic [ELEM_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            r_mem[addr] <= wdata;
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: walks LANES element addresses (base + k*stride) one
// per cycle against a private RAM, collecting load data and a range-error flag.
module vector_lsu
    import vlsu_pkg::*;
#(
    parameter int LANES    = 8,
    parameter int ELEM_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 32,
    parameter int STRIDE_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [ADDR_W-1:0]       req_base,
    input  logic [STRIDE_W-1:0]     req_stride,
    input  logic [LANES*ELEM_W-1:0] req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [LANES*ELEM_W-1:0] rsp_rdata,
    output logic                    rsp_err
);

    localparam int CW  = $clog2(LANES + 1);
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RAW = $clog2(DEPTH);

    vlsu_state_e                   r_state, w_next;
    logic                          r_store;
    logic [ADDR_W-1:0]             r_addr, r_stride;
    logic [LANES-1:0][ELEM_W-1:0]  r_wdata, r_rdata;
    logic [CW-1:0]                 r_cnt;
    logic                          r_err;
    logic                          r_cap_vld;
    logic [LW-1:0]                 r_cap_lane;

    vlsu_op_e                      w_op;
    logic [ADDR_W-1:0]             w_stride;
    logic                          w_last, w_oob, w_issue, w_we;
    logic [LW-1:0]                 w_lane;
    logic [ELEM_W-1:0]             w_ram_rdata;

    assign w_op     = vlsu_op_e'(req_op);
    assign w_stride = ((w_op == VLSU_LOAD_S) || (w_op == VLSU_STORE_S))
                      ? ADDR_W'($signed(req_stride)) : ADDR_W'(1);
    assign w_issue  = (r_state == ST_ISSUE);
    assign w_last   = (r_cnt == CW'(LANES - 1));
    assign w_oob    = (r_addr >= ADDR_W'(DEPTH));
    assign w_lane   = r_cnt[LW-1:0];
    // RAM ports depend only on registered state, never on the handshake inputs
    assign w_we     = w_issue && r_store && !w_oob;

    lsu_ram #(.DEPTH(DEPTH), .ELEM_W(ELEM_W)) u_ram (
        .clk   (clk),
        .we    (w_we),
        .addr  (r_addr[RAW-1:0]),
        .wdata (r_wdata[w_lane]),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_next = ST_ISSUE;
            ST_ISSUE: if (w_last)    w_next = r_store ? ST_RESP : ST_DRAIN;
            ST_DRAIN: w_next = ST_RESP;
            ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_store    <= 1'b0;
            r_addr     <= '0;
            r_stride   <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cap_vld  <= 1'b0;
            r_cap_lane <= '0;
        end else begin
            r_cap_vld <= 1'b0;
            if (r_state == ST_IDLE && req_valid) begin
                r_store  <= is_store(w_op);
                r_addr   <= req_base;
                r_stride <= w_stride;
                r_wdata  <= req_wdata;
                r_cnt    <= '0;
                r_rdata  <= '0;
                r_err    <= 1'b0;
            end
            if (w_issue) begin
                r_addr     <= r_addr + r_stride;
                r_cnt      <= r_cnt + CW'(1);
                r_cap_vld  <= !r_store && !w_oob;
                r_cap_lane <= w_lane;
                if (w_oob) r_err <= 1'b1;
            end
            // out-of-range lanes are never captured, so they keep the cleared 0
            if (r_cap_vld)
                r_rdata[r_cap_lane] <= w_ram_rdata;
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_vector_lsu.sv
// Randomised bench for vector_lsu with a behavioural memory model.
module tb_vector_lsu;

    localparam int LANES = 8;
    localparam int EW    = 32;
    localparam int DEPTH = 1024;
    localparam int W     = LANES * EW;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]    req_op;
    logic [31:0]   req_base;
    logic [15:0]   req_stride;
    logic [W-1:0]  req_wdata, rsp_rdata;

    logic [31:0]   ref_mem [DEPTH];
    int            n_vec = 0;
    int            n_err = 0;

    vector_lsu #(.LANES(LANES), .ELEM_W(EW), .DEPTH(DEPTH), .ADDR_W(32), .STRIDE_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_base(req_base), .req_stride(req_stride), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Lane k touches base + k*stride (mod 2^32); anything >= DEPTH is an error lane.
    task automatic model(input logic [1:0] op, input logic [31:0] base, input logic [15:0] stride,
                         input logic [W-1:0] wd, output logic [W-1:0] rd, output logic err);
        logic [31:0] st, a;
        st  = op[1] ? {{16{stride[15]}}, stride} : 32'd1;
        rd  = '0;
        err = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            a = base + 32'(k) * st;
            if (a >= DEPTH) err = 1'b1;
            else if (op[0]) ref_mem[a] = wd[k*EW +: EW];
            else rd[k*EW +: EW] = ref_mem[a];
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] base, input logic [15:0] stride,
                          input logic [W-1:0] wd, output logic [W-1:0] rd, output logic err,
                          output int lat);
        @(negedge clk);
        req_op = op; req_base = base; req_stride = stride; req_wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) break;
        end
        rd  = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*EW +: EW] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== '0)   begin n_err++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0)   begin n_err++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    endtask

    task automatic test_fill();
        logic [W-1:0] wd, rd, erd; logic err, eerr; int lat;
        for (int b = 0; b < DEPTH; b += LANES) begin
            wd = rand_vec();
            model(2'd1, 32'(b), 16'd0, wd, erd, eerr);
            do_req(2'd1, 32'(b), 16'd0, wd, rd, err, lat);
            n_vec++; if (err !== 1'b0 || lat != 8) begin n_err++; $display("FAIL fill base %0d err %b lat %0d want 0/8", b, err, lat); end
        end
    endtask

    task automatic test_unit();
        logic [W-1:0] wd, rd, exp_rd; logic err, eerr; int lat;
        for (int k = 0; k < LANES; k++) wd[k*EW +: EW] = 32'h11 * (k + 1);
        model(2'd1, 32'd16, 16'd0, wd, exp_rd, eerr);
        do_req(2'd1, 32'd16, 16'd0, wd, rd, err, lat);
        n_vec++; if (lat != 8)     begin n_err++; $display("FAIL unit_store_latency got %0d want 8", lat); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL unit_store_err got %b want 0", err); end
        n_vec++; if (rd !== '0)    begin n_err++; $display("FAIL unit_store_rdata got %h want 0", rd); end
        model(2'd0, 32'd16, 16'd0, '0, exp_rd, eerr);
        do_req(2'd0, 32'd16, 16'd0, '0, rd, err, lat);
        n_vec++; if (lat != 9)     begin n_err++; $display("FAIL unit_load_latency got %0d want 9", lat); end
        n_vec++; if (rd !== wd)    begin n_err++; $display("FAIL unit_load_rdata got %h want %h", rd, wd); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL unit_load_err got %b want 0", err); end
    endtask

    task automatic test_strided();
        logic [W-1:0] wd, rd, erd, exp_rd; logic err, eerr; int lat;
        for (int b = 0; b < 16; b += LANES) begin
            for (int k = 0; k < LANES; k++) wd[k*EW +: EW] = 32'(b + k);
            model(2'd1, 32'(b), 16'd0, wd, erd, eerr);
            do_req(2'd1, 32'(b), 16'd0, wd, rd, err, lat);
        end
        for (int k = 0; k < LANES; k++) exp_rd[k*EW +: EW] = 32'(14 - 2 * k);
        do_req(2'd2, 32'd14, 16'hFFFE, '0, rd, err, lat);
        n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL stride_neg2 got %h want %h", rd, exp_rd); end
        n_vec++; if (err !== 1'b0 || lat != 9) begin n_err++; $display("FAIL stride_neg2_err_lat got %b/%0d want 0/9", err, lat); end
        wd = rand_vec();
        model(2'd3, 32'd5, 16'd0, wd, erd, eerr);
        do_req(2'd3, 32'd5, 16'd0, wd, rd, err, lat);
        n_vec++; if (err !== 1'b0 || lat != 8) begin n_err++; $display("FAIL stride0_store got %b/%0d want 0/8", err, lat); end
        do_req(2'd0, 32'd5, 16'd0, '0, rd, err, lat);
        n_vec++; if (rd[EW-1:0] !== wd[7*EW +: EW]) begin n_err++; $display("FAIL stride0_last_wins got %h want %h", rd[EW-1:0], wd[7*EW +: EW]); end
        wd = '0;
        model(2'd2, 32'd9, 16'd0, wd, exp_rd, eerr);
        do_req(2'd2, 32'd9, 16'd0, wd, rd, err, lat);
        n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL stride0_load got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_range();
        logic [W-1:0] wd, rd, exp_rd; logic err, eerr; int lat;
        model(2'd0, 32'd1020, 16'd0, '0, exp_rd, eerr);
        do_req(2'd0, 32'd1020, 16'd0, '0, rd, err, lat);
        n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL range_load got %h want %h", rd, exp_rd); end
        n_vec++; if (rd[W-1:4*EW] !== '0) begin n_err++; $display("FAIL range_load_hi got %h want 0", rd[W-1:4*EW]); end
        n_vec++; if (err !== 1'b1 || lat != 9) begin n_err++; $display("FAIL range_load_err got %b/%0d want 1/9", err, lat); end
        wd = rand_vec();
        model(2'd1, 32'd1020, 16'd0, wd, exp_rd, eerr);
        do_req(2'd1, 32'd1020, 16'd0, wd, rd, err, lat);
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL range_store_err got %b want 1", err); end
        model(2'd0, 32'd0, 16'd0, '0, exp_rd, eerr);
        do_req(2'd0, 32'd0, 16'd0, '0, rd, err, lat);
        n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL range_store_nowrap got %h want %h", rd, exp_rd); end
        model(2'd2, 32'd2, 16'hFFFF, '0, exp_rd, eerr);
        do_req(2'd2, 32'd2, 16'hFFFF, '0, rd, err, lat);
        n_vec++; if (rd !== exp_rd || err !== eerr) begin n_err++; $display("FAIL range_neg_wrap got %h/%b want %h/%b", rd, err, exp_rd, eerr); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_rd, junk, d; logic eerr, e; int lat;
        model(2'd0, 32'd300, 16'd0, '0, exp_rd, eerr);
        @(negedge clk);
        req_op = 2'd0; req_base = 32'd300; req_stride = 16'd0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
        junk = rand_vec();
        req_op = 2'd1; req_base = 32'd300; req_wdata = junk; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold cyc %0d v/r/e/rdy got %b/%h/%b/%b want 1/%h/0/0", c, rsp_valid, rsp_rdata, rsp_err, req_ready, exp_rd);
            end
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready got %b want 1", req_ready); end
        do_req(2'd0, 32'd300, 16'd0, '0, d, e, lat);
        n_vec++; if (d !== exp_rd) begin n_err++; $display("FAIL hold_ignored_store got %h want %h", d, exp_rd); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp_rd, rd; logic eerr, err; int lat;
        @(negedge clk);
        req_op = 2'd0; req_base = 32'd40; req_stride = 16'd0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL mid_reset rdy/v/d/e got %b/%b/%h/%b want 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        model(2'd0, 32'd40, 16'd0, '0, exp_rd, eerr);
        do_req(2'd0, 32'd40, 16'd0, '0, rd, err, lat);
        n_vec++; if (rd !== exp_rd || err !== 1'b0 || lat != 9) begin
            n_err++; $display("FAIL post_reset_load got %h/%b/%0d want %h/0/9", rd, err, lat, exp_rd);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] wd, rd, exp_rd; logic err, eerr; int lat;
        logic [1:0] op; logic [31:0] base; logic [15:0] st;
        for (int i = 0; i < 60; i++) begin
            op   = 2'($urandom_range(0, 3));
            base = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 6)) : 32'($urandom_range(0, 1100));
            st   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 16)) - 8);
            wd   = rand_vec();
            model(op, base, st, wd, exp_rd, eerr);
            do_req(op, base, st, wd, rd, err, lat);
            n_vec++;
            if (rd !== exp_rd || err !== eerr || lat != (op[0] ? 8 : 9)) begin
                n_err++;
                $display("FAIL rand %0d op %0d base %0d st %0d got %h/%b/%0d want %h/%b/%0d",
                         i, op, base, $signed(st), rd, err, lat, exp_rd, eerr, op[0] ? 8 : 9);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_rd; logic eerr; int nrsp;
        model(2'd0, 32'd500, 16'd3, '0, exp_rd, eerr);
        @(negedge clk);
        req_op = 2'd0; req_base = 32'd500; req_stride = 16'd3; req_valid = 1'b1; rsp_ready = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                nrsp++;
                n_vec++; if (rsp_rdata !== exp_rd || rsp_err !== 1'b0) begin
                    n_err++; $display("FAIL b2b rsp %0d got %h/%b want %h/0", nrsp, rsp_rdata, rsp_err, exp_rd);
                end
            end
        end
        req_valid = 1'b0;
        n_vec++; if (nrsp < 3) begin n_err++; $display("FAIL b2b_count got %0d want >=3", nrsp); end
        for (int i = 0; i < 30 && !req_ready; i++) @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_base = '0; req_stride = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        test_reset();
        test_fill();
        test_unit();
        test_strided();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
